scoreboard_register_file: RTL and testbench

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

---
 rtl/scoreboard_register_file_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 42 ++++
 rtl/scoreboard_register_file.sv | 120 ++++++++++++
 tb/tb_scoreboard_register_file.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_register_file_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package scoreboard_register_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_PC_INC   = 4;

    // Minimum of 1 bit so a 2-entry file still gets a usable address port.
    function automatic int calc_aw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: a claim marks a load outstanding; write-back or flush clears it.
module rf_scoreboard
    import scoreboard_register_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = calc_aw(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                claim_en,
    input  logic [AW-1:0]       claim_addr,
    input  logic                clr_en,
    input  logic [AW-1:0]       clr_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pending_next;

    // A claim beats both flush and write-back: the newer load is still outstanding.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (claim_en && (claim_addr == AW'(i))) begin
                pending_next[i] = 1'b1;
            end else if (flush) begin
                pending_next[i] = 1'b0;
            end else if (clr_en && (clr_addr == AW'(i))) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Multi-ported register file with write bypass, per-register load scoreboard and a PC register.
module scoreboard_register_file
    import scoreboard_register_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int PC_IDX   = 15,
    parameter int PC_INC   = DEF_PC_INC,
    parameter int ZERO_REG = 0,
    localparam int AW      = calc_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [AW-1:0]            claim_addr,
    input  logic                     flush,
    input  logic                     pc_en,
    input  logic                     pc_ld,
    input  logic [DATA_W-1:0]        pc_target,
    output logic [DATA_W-1:0]        pc_out
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                wr_ok;
    logic                claim_ok;
    logic [DATA_W-1:0]   pc_next;

    assign wr_ok    = wr_en    && !((ZERO_REG != 0) && (wr_addr == '0));
    assign claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));
    assign pc_out   = regs[PC_IDX];

    always_comb begin
        pc_next = regs[PC_IDX];
        if (wr_ok && (wr_addr == AW'(PC_IDX))) begin
            pc_next = wr_data;
        end else if (pc_ld) begin
            pc_next = pc_target;
        end else if (pc_en) begin
            pc_next = regs[PC_IDX] + DATA_W'(PC_INC);
        end
    end

    // Out-of-range write addresses match no entry and fall through as no-ops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == PC_IDX) begin
                    regs[i] <= pc_next;
                end else if (wr_ok && (wr_addr == AW'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .claim_en   (claim_ok),
        .claim_addr (claim_addr),
        .clr_en     (wr_ok),
        .clr_addr   (wr_addr),
        .flush      (flush),
        .pending    (pending)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              in_range;
        logic              wr_hit;
        logic              claim_hit;
        logic [DATA_W-1:0] data_k;
        logic              busy_k;

        assign ra        = rd_addr[k*AW +: AW];
        assign wr_hit    = wr_en && !reset && (wr_addr == ra);
        assign claim_hit = claim_ok && (claim_addr == ra);

        // A write retiring the load hides busy unless a new load claims the same entry.
        always_comb begin
            data_k   = '0;
            busy_k   = 1'b0;
            in_range = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ra == AW'(i)) begin
                    data_k   = regs[i];
                    busy_k   = pending[i];
                    in_range = 1'b1;
                end
            end
            if (in_range && wr_hit) begin
                data_k = wr_data;
                if (!claim_hit) busy_k = 1'b0;
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                data_k = '0;
                busy_k = 1'b0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data_k;
        assign rd_busy[k]                  = busy_k;
    end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor pops and compares them.
module tb_scoreboard_register_file;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           claim_en = 1'b0;
    logic [AW-1:0]  claim_addr = '0;
    logic           flush = 1'b0;
    logic           pc_en = 1'b0;
    logic           pc_ld = 1'b0;
    logic [DW-1:0]  pc_target = '0;
    logic [DW-1:0]  pc_out;

    scoreboard_register_file #(
        .DATA_W   (DW),
        .NUM_REGS (16),
        .NUM_RD   (NR),
        .PC_IDX   (15),
        .PC_INC   (4),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush),
        .pc_en      (pc_en),
        .pc_ld      (pc_ld),
        .pc_target  (pc_target),
        .pc_out     (pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic push(input int kind, input int port, input logic [31:0] v, input string nm);
        exp_t e;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic exp_rd(input int k, input logic [31:0] v);
        push(0, k, v, $sformatf("rd_data%0d", k));
    endtask

    task automatic exp_busy(input int k, input logic b);
        push(1, k, {31'b0, b}, $sformatf("rd_busy%0d", k));
    endtask

    task automatic exp_pc(input logic [31:0] v);
        push(2, 0, v, "pc_out");
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
        pc_en = 1'b0; pc_ld = 1'b0; pc_target = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic claim(input logic [AW-1:0] a);
        claim_en = 1'b1; claim_addr = a;
    endtask

    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    0:       act = rd_data[e.port*DW +: DW];
                    1:       act = {31'b0, rd_busy[e.port]};
                    default: act = pc_out;
                endcase
                n_vec++;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s at %0t: got %h, expected %h", e.name, $time, act, e.val);
                end
            end
        end
    end

    initial begin
        // Reset state; a write during reset is neither stored nor bypassed.
        step(); wr(3, 32'h1234); set_rd(0, 3);
        exp_rd(0, 0); exp_busy(0, 0); exp_pc(0);
        step(); reset = 1'b0; exp_rd(0, 0);

        // Write then read back, plus same-cycle bypass.
        step(); wr(3, 32'hDEADBEEF); exp_rd(0, 32'hDEADBEEF);
        step(); wr(4, 32'h55); set_rd(1, 4);
        exp_rd(0, 32'hDEADBEEF); exp_rd(1, 32'h55);
        step(); exp_rd(1, 32'h55);

        // Claim latency and write-back clearing busy.
        step(); claim(5); set_rd(0, 5); exp_busy(0, 0);
        step(); exp_busy(0, 1);
        step(); wr(5, 32'h10); exp_busy(0, 0); exp_rd(0, 32'h10);
        step(); exp_rd(0, 32'h10); exp_busy(0, 0);

        // PC increment, load and write-port priority.
        step(); wr(15, 32'h100); exp_pc(0);
        step(); pc_en = 1'b1; exp_pc(32'h100);
        step(); pc_en = 1'b1; exp_pc(32'h104);
        step(); pc_en = 1'b1; exp_pc(32'h108);
        step(); pc_ld = 1'b1; pc_target = 32'h200; pc_en = 1'b1; exp_pc(32'h10C);
        step(); wr(15, 32'h300); pc_ld = 1'b1; pc_target = 32'h999; set_rd(2, 15);
        exp_pc(32'h200); exp_rd(2, 32'h300);
        step(); exp_pc(32'h300); exp_rd(2, 32'h300);

        // Claim+write on the same entry, then flush together with a claim.
        step(); claim(2); wr(2, 32'hABC); set_rd(0, 2);
        exp_busy(0, 0); exp_rd(0, 32'hABC);
        step(); claim(9); exp_busy(0, 1); exp_rd(0, 32'hABC);
        step(); flush = 1'b1; claim(7); set_rd(0, 9); set_rd(1, 7);
        exp_busy(0, 1); exp_busy(1, 0);
        step(); set_rd(2, 2); set_rd(3, 5);
        exp_busy(0, 0); exp_busy(1, 1); exp_busy(2, 0); exp_busy(3, 0);

        // Hard-wired zero register; four ports reading concurrently.
        step(); wr(0, 32'hFF); claim(0); set_rd(0, 0); exp_rd(0, 0);
        step(); set_rd(1, 3); set_rd(2, 4); set_rd(3, 5);
        exp_rd(0, 0); exp_busy(0, 0);
        exp_rd(1, 32'hDEADBEEF); exp_rd(2, 32'h55); exp_rd(3, 32'h10);

        // PC wraps modulo 2^32.
        step(); wr(15, 32'hFFFFFFFC); exp_pc(32'h300);
        step(); pc_en = 1'b1; exp_pc(32'hFFFFFFFC);
        step(); exp_pc(0);

        // Asynchronous reset between edges, then resume.
        step(); wr(1, 32'h77); pc_ld = 1'b1; pc_target = 32'h500;
        step(); claim(6); set_rd(0, 1); exp_rd(0, 32'h77); exp_pc(32'h500);
        step(); set_rd(1, 6); exp_busy(1, 1); exp_rd(0, 32'h77);
        step(); reset = 1'b1; exp_rd(0, 0); exp_busy(1, 0); exp_pc(0);
        step(); reset = 1'b0; pc_en = 1'b1; exp_pc(0);
        step(); exp_pc(32'h4); exp_rd(0, 0);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
